// File: rtl/icache_fetch.sv
// -----------------------------------------------------------------------------
// icache_fetch
//   Direct-mapped, read-only instruction cache with one 32-bit word per line.
//   It sits between the fetch stage and the icache port of the memory controller.
//   A hit returns the word on the cycle after the request. A miss makes one word
//   fetch from the controller, fills the line and then forwards the word. flush
//   squashes delivery of an in-flight miss. The line is still filled.
//
// Ports
//   clk_in, rst_in        clock; asynchronous active-high reset
//   rdy_in                global ready; while low, nothing changes
//   flush                 branch redirect; drops the current or in-flight fetch
//   fetch_valid/fetch_pc  request from the fetch stage (pc[1:0] ignored)
//   fetch_ready           high while idle, so a request can be accepted
//   inst_ready/inst_out   one-cycle registered pulse carrying the instruction
//   icache_in             miss request to the controller (held until received)
//   icache_address_in     word-aligned miss address
//   icache_received       controller accepted the miss request
//   icache_task_out       controller finished; value_load is valid
//   value_load            fetched word
// -----------------------------------------------------------------------------
module icache_fetch #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   output logic        fetch_ready,
   output logic        inst_ready,
   output logic [31:0] inst_out,
   output logic        icache_in,
   output logic [31:0] icache_address_in,
   input  logic        icache_received,
   input  logic        icache_task_out,
   input  logic [31:0] value_load
);

   localparam int LINES = 1 << INDEX_BITS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]            r_state;
   logic [LINES-1:0]      r_valid;
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [31:0]           r_data [LINES];
   logic [INDEX_BITS-1:0] r_miss_idx;
   logic [TAG_BITS-1:0]   r_miss_tag;
   logic                  r_squash;
   logic                  r_inst_ready;
   logic [31:0]           r_inst_out;
   logic                  r_icache_in;
   logic [31:0]           r_icache_address;

   logic [INDEX_BITS-1:0] w_idx;
   logic [TAG_BITS-1:0]   w_tag;
   logic                  w_hit;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_unused_ok;

   assign w_idx       = fetch_pc[INDEX_BITS+1:2];
   assign w_tag       = fetch_pc[31:INDEX_BITS+2];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_accept    = (r_state == S_IDLE) && fetch_valid && !flush;
   assign w_unused_ok = &{1'b0, fetch_pc[1:0]};

   // The controller's completion is accepted in WAIT. It is also accepted in REQ
   // when received and task_out arrive together, which happens with a
   // zero-latency controller.
   assign w_done = icache_task_out &&
                   ((r_state == S_WAIT) || ((r_state == S_REQ) && icache_received));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state          <= S_IDLE;
         r_valid          <= '0;
         r_miss_idx       <= '0;
         r_miss_tag       <= '0;
         r_squash         <= 1'b0;
         r_inst_ready     <= 1'b0;
         r_inst_out       <= '0;
         r_icache_in      <= 1'b0;
         r_icache_address <= '0;
      end else if (rdy_in) begin
         r_inst_ready <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_hit) begin
                     r_inst_ready <= 1'b1;
                     r_inst_out   <= r_data[w_idx];
                  end else begin
                     r_miss_idx       <= w_idx;
                     r_miss_tag       <= w_tag;
                     r_icache_in      <= 1'b1;
                     r_icache_address <= {fetch_pc[31:2], 2'b00};
                     r_state          <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               // The request stays on the bus after a flush, so the handshake
               // still completes. Only the delivery is dropped.
               if (icache_received) begin
                  r_icache_in <= 1'b0;
                  r_state     <= S_WAIT;
               end
               if (flush) r_squash <= 1'b1;
            end
            S_WAIT: begin
               if (flush) r_squash <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase

         // NOTE: the completion path is written after the case on purpose. With
         // non-blocking assignments the last write wins, so it overrides the
         // REQ->WAIT move and the squash set for a zero-latency completion.
         if (w_done) begin
            r_valid[r_miss_idx] <= 1'b1;
            if (!r_squash && !flush) begin
               r_inst_ready <= 1'b1;
               r_inst_out   <= value_load;
            end
            r_squash <= 1'b0;
            r_state  <= S_IDLE;
         end
      end
   end

   // NOTE: the tag and data arrays are deliberately not reset. r_valid alone marks
   // a line as meaningful, and without a reset the arrays can map onto plain RAM.
   always_ff @(posedge clk_in) begin
      if (rdy_in && w_done) begin
         r_tag[r_miss_idx]  <= r_miss_tag;
         r_data[r_miss_idx] <= value_load;
      end
   end

   assign fetch_ready       = (r_state == S_IDLE);
   assign inst_ready        = r_inst_ready;
   assign inst_out          = r_inst_out;
   assign icache_in         = r_icache_in;
   assign icache_address_in = r_icache_address;

endmodule
